inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 69 ++++++
 rtl/inst_fifo.sv | 54 +++++
 rtl/inst_encoder.sv | 111 +++++++++++
 tb/tb_inst_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants: instruction kinds, opcodes, ALU control codes.
// Also imported by the control-unit decoder so both sides agree on ALU codes.
package inst_encoder_pkg;

    typedef enum logic [3:0] {
        K_R     = 4'd0,
        K_I     = 4'd1,
        K_LOAD  = 4'd2,
        K_STORE = 4'd3,
        K_BR    = 4'd4,
        K_LUI   = 4'd5,
        K_AUIPC = 4'd6,
        K_JAL   = 4'd7,
        K_JALR  = 4'd8,
        K_CSR   = 4'd9
    } kind_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b10111;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic       ok;
        logic [6:0] f7;
        logic [2:0] f3;
    } alu_enc_t;

    // Inverse of the decoder's funct7/funct3 -> ALU code mapping.
    function automatic alu_enc_t alu_map(input logic [4:0] c);
        alu_enc_t r;
        r = '{ok: 1'b1, f7: F7_BASE, f3: 3'b000};
        case (c)
            ALU_ADD:  r.f3 = 3'b000;
            ALU_SUB:  begin r.f3 = 3'b000; r.f7 = F7_ALT; end
            ALU_SLL:  r.f3 = 3'b001;
            ALU_SLT:  r.f3 = 3'b010;
            ALU_SLTU: r.f3 = 3'b011;
            ALU_XOR:  r.f3 = 3'b100;
            ALU_SRL:  r.f3 = 3'b101;
            ALU_SRA:  begin r.f3 = 3'b101; r.f7 = F7_ALT; end
            ALU_OR:   r.f3 = 3'b110;
            ALU_AND:  r.f3 = 3'b111;
            default:  r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular FIFO of encoded words with valid/ready on both sides.
// Head data comes straight from storage, so it holds while the consumer stalls.
module inst_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder feeding an in-order output FIFO with word addresses.
// Define INST_ENC_CSR_EN to enable encoding of CSR requests (kind 9).
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_aluctl,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    alu_enc_t    alu;
    logic        is_shift;
    logic        bad;
    logic [31:0] enc;
    logic        accept;

    assign alu      = alu_map(in_aluctl);
    assign is_shift = (in_aluctl == ALU_SLL) || (in_aluctl == ALU_SRL) ||
                      (in_aluctl == ALU_SRA);
    assign accept   = in_valid && in_ready;

    always_comb begin
        enc = '0;
        bad = 1'b0;
        case (in_kind)
            K_R: begin
                enc = {alu.f7, in_rs2, in_rs1, alu.f3, in_rd, OP_R};
                bad = !alu.ok;
            end
            K_I: begin
                if (is_shift)
                    enc = {alu.f7, in_imm[4:0], in_rs1, alu.f3, in_rd, OP_I};
                else
                    enc = {in_imm[11:0], in_rs1, alu.f3, in_rd, OP_I};
                bad = !alu.ok || (in_aluctl == ALU_SUB);
            end
            K_LOAD:
                enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            K_STORE:
                enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:0], OP_STORE};
            K_BR:
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BR};
            K_LUI:
                enc = {in_imm[31:12], in_rd, OP_LUI};
            K_AUIPC:
                enc = {in_imm[31:12], in_rd, OP_AUIPC};
            K_JAL:
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, OP_JAL};
            K_JALR:
                enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            K_CSR: begin
`ifdef INST_ENC_CSR_EN
                enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_CSR};
`else
                bad = 1'b1;
`endif
            end
            default:
                bad = 1'b1;
        endcase
    end

    // Illegal requests still handshake (fifo ready) but never reach storage.
    inst_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && !bad),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            out_addr <= BASE_ADDR;
        end else begin
            err <= accept && bad;
            if (accept && bad && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            if (out_valid && out_ready)
                out_addr <= out_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder.
// Covers encodings, illegal requests, backpressure and mid-stream reset.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_aluctl = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_cnt;

    int pass_cnt = 0;
    int total = 0;
    logic [31:0] exp_addr = 32'h0;

    typedef struct {
        logic [3:0]  k;
        logic [4:0]  a;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        string       name;
    } vec_t;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_aluctl (in_aluctl),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    task automatic drive(input logic [3:0] k, input logic [4:0] a,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_kind = k; in_aluctl = a; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] a,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        drive(k, a, f3, rd, rs1, rs2, imm);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else pass_cnt++;
        total++; if (err_cnt !== 8'd0) $display("FAIL rst_errcnt got=%0d exp=0", err_cnt); else pass_cnt++;
        total++; if (out_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", out_addr); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_inready got=%b exp=1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_idle_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_encode();
        vec_t v[$];
        v.push_back('{4'd0, 5'b00000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, "add"});
        v.push_back('{4'd1, 5'b00110, 3'd0, 5'd5, 5'd6, 5'd0, 32'd3,        32'h40335293, "srai"});
        v.push_back('{4'd3, 5'b00000, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, "sw"});
        v.push_back('{4'd0, 5'b10000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, "sub"});
        v.push_back('{4'd1, 5'b00100, 3'd0, 5'd1, 5'd1, 5'd0, 32'd31,       32'h01F09093, "slli"});
        v.push_back('{4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, "addi_m1"});
        v.push_back('{4'd2, 5'b00000, 3'd2, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12283, "lw"});
        v.push_back('{4'd4, 5'b00000, 3'd0, 5'd0, 5'd1, 5'd2, 32'd16,       32'h00208863, "beq16"});
        v.push_back('{4'd4, 5'b00000, 3'd0, 5'd0, 5'd1, 5'd2, 32'd17,       32'h00208863, "beq_bit0"});
        v.push_back('{4'd7, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd9,        32'h008000EF, "jal_bit0"});
        v.push_back('{4'd8, 5'b00000, 3'd5, 5'd0, 5'd1, 5'd0, 32'd0,        32'h00008067, "jalr"});
        v.push_back('{4'd5, 5'b00000, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, "lui"});
        v.push_back('{4'd6, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00001000, 32'h00001097, "auipc"});
        foreach (v[i]) begin
            send(v[i].k, v[i].a, v[i].f3, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            total++; if (out_valid !== 1'b1) $display("FAIL %s_valid got=%b exp=1", v[i].name, out_valid); else pass_cnt++;
            total++; if (out_instr !== v[i].exp) $display("FAIL %s_instr got=%h exp=%h", v[i].name, out_instr, v[i].exp); else pass_cnt++;
            total++; if (out_addr !== exp_addr) $display("FAIL %s_addr got=%h exp=%h", v[i].name, out_addr, exp_addr); else pass_cnt++;
            pop();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL enc_drain got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_illegal();
        send(4'd0, 5'b11111, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        total++; if (err !== 1'b1) $display("FAIL ill_r_err got=%b exp=1", err); else pass_cnt++;
        total++; if (err_cnt !== 8'd1) $display("FAIL ill_r_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL ill_r_valid got=%b exp=0", out_valid); else pass_cnt++;
        send(4'd1, 5'b10000, 3'd0, 5'd1, 5'd1, 5'd0, 32'd5);
        total++; if (err !== 1'b1) $display("FAIL ill_isub_err got=%b exp=1", err); else pass_cnt++;
        total++; if (err_cnt !== 8'd2) $display("FAIL ill_isub_cnt got=%0d exp=2", err_cnt); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (err !== 1'b0) $display("FAIL ill_pulse_end got=%b exp=0", err); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL ill_no_out got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (err_cnt !== 8'd2) $display("FAIL ill_cnt_hold got=%0d exp=2", err_cnt); else pass_cnt++;
        send(4'd10, 5'b00000, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
        total++; if (err_cnt !== 8'd3) $display("FAIL ill_kind10_cnt got=%0d exp=3", err_cnt); else pass_cnt++;
        send(4'd15, 5'b00000, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
        total++; if (err_cnt !== 8'd4) $display("FAIL ill_kind15_cnt got=%0d exp=4", err_cnt); else pass_cnt++;
        send(4'd9, 5'b00000, 3'd1, 5'd5, 5'd1, 5'd0, 32'h00000300);
`ifdef INST_ENC_CSR_EN
        total++; if (err !== 1'b0) $display("FAIL csr_err got=%b exp=0", err); else pass_cnt++;
        total++; if (out_instr !== 32'h300092F3) $display("FAIL csr_instr got=%h exp=300092f3", out_instr); else pass_cnt++;
        total++; if (out_addr !== exp_addr) $display("FAIL csr_addr got=%h exp=%h", out_addr, exp_addr); else pass_cnt++;
        pop();
`else
        total++; if (err !== 1'b1) $display("FAIL csr_off_err got=%b exp=1", err); else pass_cnt++;
        total++; if (err_cnt !== 8'd5) $display("FAIL csr_off_cnt got=%0d exp=5", err_cnt); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL csr_off_valid got=%b exp=0", out_valid); else pass_cnt++;
`endif
        drive(4'd0, 5'b11111, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        repeat (260) @(posedge clk);
        #1 in_valid = 1'b0;
        total++; if (err_cnt !== 8'd255) $display("FAIL ill_sat_cnt got=%0d exp=255", err_cnt); else pass_cnt++;
        total++; if (err !== 1'b1) $display("FAIL ill_sat_err got=%b exp=1", err); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_i;
        do_reset();
        total++; if (err_cnt !== 8'd0) $display("FAIL bp_cnt_clear got=%0d exp=0", err_cnt); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            send(4'd0, 5'b00000, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'd0);
            if (i == 2) begin
                total++; if (in_ready !== 1'b1) $display("FAIL bp_ready3 got=%b exp=1", in_ready); else pass_cnt++;
            end
        end
        total++; if (in_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", in_ready); else pass_cnt++;
        drive(4'd0, 5'b00000, 3'd0, 5'd5, 5'd0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_still_full got=%b exp=0", in_ready); else pass_cnt++;
        total++; if (out_instr !== 32'h000000B3) $display("FAIL bp_hold_instr got=%h exp=000000b3", out_instr); else pass_cnt++;
        total++; if (out_addr !== 32'h0) $display("FAIL bp_hold_addr got=%h exp=0", out_addr); else pass_cnt++;
        pop();
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_refull got=%b exp=0", in_ready); else pass_cnt++;
        for (int i = 2; i <= 5; i++) begin
            exp_i = (32'(i) << 7) | 32'h33;
            total++; if (out_addr !== exp_addr) $display("FAIL bp_addr%0d got=%h exp=%h", i, out_addr, exp_addr); else pass_cnt++;
            total++; if (out_instr !== exp_i) $display("FAIL bp_order%0d got=%h exp=%h", i, out_instr, exp_i); else pass_cnt++;
            pop();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (out_addr !== 32'h14) $display("FAIL bp_final_addr got=%h exp=14", out_addr); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++)
            send(4'd0, 5'b00000, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'd0);
        total++; if (out_valid !== 1'b1) $display("FAIL mid_queued got=%b exp=1", out_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (out_addr !== 32'h0) $display("FAIL mid_rst_addr got=%h exp=0", out_addr); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_discard got=%b exp=0", out_valid); else pass_cnt++;
        send(4'd0, 5'b00000, 3'd0, 5'd7, 5'd0, 5'd0, 32'd0);
        total++; if (out_valid !== 1'b1) $display("FAIL mid_new_valid got=%b exp=1", out_valid); else pass_cnt++;
        total++; if (out_addr !== 32'h0) $display("FAIL mid_new_addr got=%h exp=0", out_addr); else pass_cnt++;
        total++; if (out_instr !== 32'h000003B3) $display("FAIL mid_new_instr got=%h exp=000003b3", out_instr); else pass_cnt++;
        pop();
    endtask

    initial begin
        test_reset();
        test_encode();
        test_illegal();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
